// File: rtl/ftl_blk_xfer.sv
// FTL block engine: writes back the dirty cached block, then fetches the requested one.
// Optional FTL_XFER_CHECKSUM_EN adds xfer_sum, the wrapping sum of the last fetched block.
module ftl_blk_xfer #(
   parameter int                BLOCK_WORDS_LOG2 = 7,
   parameter int                MEM_AW           = 24,
   parameter logic [MEM_AW-1:0] MEM_BASE         = 24'h080000
) (
   input  logic                        clk_50,
   input  logic                        reset,
   input  logic                        logical_init_done,
   input  logic                        wb_read,
   input  logic                        wb_write,
   input  logic [9:0]                  wb_block,
   output logic                        wb_ack,
   output logic                        wb_done,
   output logic [BLOCK_WORDS_LOG2-1:0] bram_addr,
   output logic                        bram_wren,
   output logic [31:0]                 bram_data,
   input  logic [31:0]                 bram_q,
   output logic                        mem_req,
   output logic                        mem_we,
   output logic [MEM_AW-1:0]           mem_addr,
   output logic [31:0]                 mem_wdata,
   input  logic [31:0]                 mem_rdata,
   input  logic                        mem_ack,
`ifdef FTL_XFER_CHECKSUM_EN
   output logic [31:0]                 xfer_sum,
`endif
   output logic                        busy
);

   localparam int W = BLOCK_WORDS_LOG2;
   typedef logic [W-1:0] cnt_t;
   localparam cnt_t LAST = '1;

   typedef enum logic [2:0] {
      IDLE, DECIDE, WB_RD, WB_MEM, FE_REQ, FE_WR, DONE, RELEASE
   } state_t;

   state_t            state_q;
   logic [2:0]        rd_sync_q, wr_sync_q;
   logic              rd_s, wr_s;
   logic [9:0]        tgt_q, cached_blk_q;
   logic              tgt_w_q, cached_valid_q, dirty_q;
   cnt_t              cnt_q, cnt_d;
   logic              rd_wait_q;
   logic              ack_q, done_q, wren_q, req_q, we_q;
   cnt_t              baddr_q;
   logic [31:0]       bdata_q, wdata_q;
   logic [MEM_AW-1:0] maddr_q;
`ifdef FTL_XFER_CHECKSUM_EN
   logic [31:0]       sum_q;
   assign xfer_sum = sum_q;
`endif

   function automatic logic [MEM_AW-1:0] addr_f(input logic [9:0] blk, input cnt_t c);
      return MEM_BASE + MEM_AW'({blk, c});
   endfunction

   assign rd_s  = rd_sync_q[2];
   assign wr_s  = wr_sync_q[2];
   assign cnt_d = cnt_q + cnt_t'(1);

   assign wb_ack    = ack_q;
   assign wb_done   = done_q;
   assign bram_addr = baddr_q;
   assign bram_wren = wren_q;
   assign bram_data = bdata_q;
   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_addr  = maddr_q;
   assign mem_wdata = wdata_q;
   assign busy      = (state_q != IDLE);

   always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) begin
         rd_sync_q <= '0;
         wr_sync_q <= '0;
      end else begin
         rd_sync_q <= {rd_sync_q[1:0], wb_read};
         wr_sync_q <= {wr_sync_q[1:0], wb_write};
      end
   end

   always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         tgt_q          <= '0;
         tgt_w_q        <= 1'b0;
         cached_blk_q   <= '0;
         cached_valid_q <= 1'b0;
         dirty_q        <= 1'b0;
         cnt_q          <= '0;
         rd_wait_q      <= 1'b0;
         ack_q          <= 1'b0;
         done_q         <= 1'b0;
         wren_q         <= 1'b0;
         req_q          <= 1'b0;
         we_q           <= 1'b0;
         baddr_q        <= '0;
         bdata_q        <= '0;
         wdata_q        <= '0;
         maddr_q        <= '0;
`ifdef FTL_XFER_CHECKSUM_EN
         sum_q          <= '0;
`endif
      end else begin
         wren_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (logical_init_done && (rd_s || wr_s)) begin
                  tgt_q   <= wb_block;
                  tgt_w_q <= wr_s;
                  ack_q   <= 1'b1;
                  state_q <= DECIDE;
               end
            end
            DECIDE: begin
               cnt_q <= '0;
               if (cached_valid_q && cached_blk_q == tgt_q) begin
                  dirty_q <= dirty_q | tgt_w_q;
                  state_q <= DONE;
               end else if (cached_valid_q && dirty_q) begin
                  baddr_q   <= '0;
                  rd_wait_q <= 1'b0;
                  state_q   <= WB_RD;
               end else begin
                  req_q   <= 1'b1;
                  we_q    <= 1'b0;
                  maddr_q <= addr_f(tgt_q, '0);
`ifdef FTL_XFER_CHECKSUM_EN
                  sum_q   <= '0;
`endif
                  state_q <= FE_REQ;
               end
            end
            WB_RD: begin
               // first cycle presents the address, second captures bram_q
               if (!rd_wait_q) begin
                  rd_wait_q <= 1'b1;
               end else begin
                  rd_wait_q <= 1'b0;
                  wdata_q   <= bram_q;
                  req_q     <= 1'b1;
                  we_q      <= 1'b1;
                  maddr_q   <= addr_f(cached_blk_q, cnt_q);
                  state_q   <= WB_MEM;
               end
            end
            WB_MEM: begin
               if (mem_ack) begin
                  req_q <= 1'b0;
                  we_q  <= 1'b0;
                  if (cnt_q == LAST) begin
                     dirty_q <= 1'b0;
                     cnt_q   <= '0;
                     req_q   <= 1'b1;
                     maddr_q <= addr_f(tgt_q, '0);
`ifdef FTL_XFER_CHECKSUM_EN
                     sum_q   <= '0;
`endif
                     state_q <= FE_REQ;
                  end else begin
                     cnt_q   <= cnt_d;
                     baddr_q <= cnt_d;
                     state_q <= WB_RD;
                  end
               end
            end
            FE_REQ: begin
               if (mem_ack) begin
                  req_q   <= 1'b0;
                  wren_q  <= 1'b1;
                  baddr_q <= cnt_q;
                  bdata_q <= mem_rdata;
                  state_q <= FE_WR;
               end
            end
            FE_WR: begin
`ifdef FTL_XFER_CHECKSUM_EN
               sum_q <= sum_q + bdata_q;
`endif
               if (cnt_q == LAST) begin
                  state_q <= DONE;
               end else begin
                  cnt_q   <= cnt_d;
                  req_q   <= 1'b1;
                  we_q    <= 1'b0;
                  maddr_q <= addr_f(tgt_q, cnt_d);
                  state_q <= FE_REQ;
               end
            end
            DONE: begin
               // a read hit on a dirty block must keep it dirty
               cached_blk_q   <= tgt_q;
               cached_valid_q <= 1'b1;
               dirty_q        <= dirty_q | tgt_w_q;
               done_q         <= 1'b1;
               state_q        <= RELEASE;
            end
            RELEASE: begin
               if (!rd_s && !wr_s) begin
                  ack_q   <= 1'b0;
                  done_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ftl_blk_xfer.sv
// Scoreboard bench for ftl_blk_xfer: directed block requests, a delaying
// memory responder, and a monitor popping expected memory/cache-RAM traffic.
module tb_ftl_blk_xfer;

   logic        clk_50 = 1'b0;
   logic        reset;
   logic        logical_init_done;
   logic        wb_read, wb_write;
   logic [9:0]  wb_block;
   logic        wb_ack, wb_done;
   logic [6:0]  bram_addr;
   logic        bram_wren;
   logic [31:0] bram_data, bram_q;
   logic        mem_req, mem_we;
   logic [23:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_ack;
   logic        busy;
`ifdef FTL_XFER_CHECKSUM_EN
   logic [31:0] xfer_sum;
`endif

   ftl_blk_xfer dut (
      .clk_50(clk_50), .reset(reset), .logical_init_done(logical_init_done),
      .wb_read(wb_read), .wb_write(wb_write), .wb_block(wb_block),
      .wb_ack(wb_ack), .wb_done(wb_done),
      .bram_addr(bram_addr), .bram_wren(bram_wren), .bram_data(bram_data),
      .bram_q(bram_q),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
`ifdef FTL_XFER_CHECKSUM_EN
      .xfer_sum(xfer_sum),
`endif
      .busy(busy)
   );

   always #10 clk_50 = ~clk_50;

   typedef struct {logic we; logic [23:0] addr; logic [31:0] data;} mtx_t;
   typedef struct {logic [6:0] a; logic [31:0] d;} btx_t;

   mtx_t mq[$];
   btx_t bq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   ack_cyc = 0;
   int   lat;
   logic rnd_en = 1'b0;

   logic [31:0] bram_m [128];

   function automatic logic [31:0] dfun(input logic [23:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   always @(posedge clk_50) begin
      cyc++;
      if (bram_wren) bram_m[bram_addr] <= bram_data;
      bram_q <= bram_m[bram_addr];
   end

   // memory responder: 0..7 cycle ack delay, checks request stability
   initial begin : responder
      logic        pending, unstable, w0;
      logic [23:0] a0;
      logic [31:0] d0;
      int          dly;
      mem_ack = 1'b0; mem_rdata = '0; pending = 1'b0; unstable = 1'b0;
      w0 = 1'b0; a0 = '0; d0 = '0; dly = 0;
      forever begin
         @(posedge clk_50); #1;
         if (reset) begin
            mem_ack = 1'b0; pending = 1'b0;
         end else if (mem_ack) begin
            mem_ack = 1'b0;
         end else if (mem_req) begin
            if (!pending) begin
               pending = 1'b1; unstable = 1'b0;
               a0 = mem_addr; w0 = mem_we; d0 = mem_wdata;
               dly = rnd_en ? int'($urandom_range(0, 7)) : 0;
            end else if (mem_addr !== a0 || mem_we !== w0 || mem_wdata !== d0) begin
               unstable = 1'b1;
            end
            if (dly == 0) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_we ? 32'h0 : dfun(mem_addr);
               pending   = 1'b0;
               checks++;
               if (unstable) begin
                  errors++;
                  $display("FAIL req_stable addr=%h now=%h", a0, mem_addr);
               end
            end else begin
               dly--;
            end
         end
      end
   end

   // monitor: pops expected traffic whenever the DUT presents it
   always @(negedge clk_50) begin : monitor
      mtx_t e;
      btx_t b;
      if (!reset) begin
         if (mem_req && mem_ack) begin
            checks++;
            if (mq.size() == 0) begin
               errors++;
               $display("FAIL mem_unexp got we=%b addr=%h", mem_we, mem_addr);
            end else begin
               e = mq.pop_front();
               if (mem_we !== e.we || mem_addr !== e.addr ||
                   (e.we && mem_wdata !== e.data)) begin
                  errors++;
                  $display("FAIL mem_txn got we=%b addr=%h wd=%h exp we=%b addr=%h wd=%h",
                           mem_we, mem_addr, mem_wdata, e.we, e.addr, e.data);
               end
            end
         end
         if (bram_wren) begin
            checks++;
            if (bq.size() == 0) begin
               errors++;
               $display("FAIL bram_unexp got a=%h d=%h", bram_addr, bram_data);
            end else begin
               b = bq.pop_front();
               if (bram_addr !== b.a || bram_data !== b.d) begin
                  errors++;
                  $display("FAIL bram_wr got a=%h d=%h exp a=%h d=%h",
                           bram_addr, bram_data, b.a, b.d);
               end
            end
         end
      end
   end

   task automatic push_fetch(input logic [23:0] base);
      for (int i = 0; i < 128; i++) begin
         mq.push_back('{1'b0, base + 24'(i), 32'h0});
         bq.push_back('{7'(i), dfun(base + 24'(i))});
      end
   endtask

   task automatic push_wb(input logic [23:0] base);
      for (int i = 0; i < 128; i++)
         mq.push_back('{1'b1, base + 24'(i), dfun(base + 24'(i))});
   endtask

   task automatic raise(input logic r, input logic w, input logic [9:0] blk);
      int n;
      @(negedge clk_50);
      wb_block = blk; wb_read = r; wb_write = w;
      n = 0;
      while (!wb_ack && n < 20) begin @(negedge clk_50); n++; end
      ack_cyc = cyc;
      checks++;
      if ({wb_ack, wb_done, busy} !== 3'b101) begin
         errors++;
         $display("FAIL ack_rise got ack/done/busy=%b%b%b exp 101", wb_ack, wb_done, busy);
      end
   endtask

   task automatic wait_done(output int l);
      int n;
      n = 0;
      while (!wb_done && n < 8000) begin @(negedge clk_50); n++; end
      l = cyc - ack_cyc;
      checks++;
      if (!wb_done) begin
         errors++;
         $display("FAIL done_timeout got done=%b exp 1", wb_done);
      end
   endtask

   task automatic drop_req();
      int n;
      @(negedge clk_50);
      wb_read = 1'b0; wb_write = 1'b0;
      n = 0;
      while (wb_ack && n < 20) begin @(negedge clk_50); n++; end
      checks++;
      if ({wb_ack, wb_done, busy} !== 3'b000) begin
         errors++;
         $display("FAIL release got ack/done/busy=%b%b%b exp 000", wb_ack, wb_done, busy);
      end
      checks++;
      if (mq.size() != 0 || bq.size() != 0) begin
         errors++;
         $display("FAIL leftover got mem=%0d bram=%0d exp 0 0", mq.size(), bq.size());
      end
   endtask

   task automatic chk_lat(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", nm, got, exp);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b1; logical_init_done = 1'b0;
      wb_read = 1'b0; wb_write = 1'b0; wb_block = '0;
      repeat (3) @(negedge clk_50);
      checks++;
      if ({wb_ack, wb_done, bram_wren, mem_req, mem_we, busy} !== 6'b0 ||
          mem_addr !== 24'h0 || bram_addr !== 7'h0) begin
         errors++;
         $display("FAIL reset_vals got flags=%b addr=%h ba=%h exp 0",
                  {wb_ack, wb_done, bram_wren, mem_req, mem_we, busy}, mem_addr, bram_addr);
      end
      reset = 1'b0;

      // request while init not done is not accepted
      @(negedge clk_50);
      wb_block = 10'd7; wb_read = 1'b1;
      repeat (20) @(negedge clk_50);
      checks++;
      if (wb_ack !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL no_init got ack=%b busy=%b exp 0 0", wb_ack, busy);
      end
      wb_read = 1'b0;
      repeat (6) @(negedge clk_50);
      logical_init_done = 1'b1;

      // read block 5, clean cache: fetch only
      push_fetch(24'h080280);
      raise(1'b1, 1'b0, 10'd5);
      wait_done(lat);
      drop_req();

      // write block 5: clean hit, no traffic, marks dirty
      raise(1'b0, 1'b1, 10'd5);
      wait_done(lat);
      chk_lat("hit_lat_w5", lat, 2);
      drop_req();

      // read block 9 with random ack delay: write-back 5 then fetch 9
      rnd_en = 1'b1;
      push_wb(24'h080280);
      push_fetch(24'h080480);
      raise(1'b1, 1'b0, 10'd9);
      wait_done(lat);
      drop_req();

      // repeated read of 9 hits
      raise(1'b1, 1'b0, 10'd9);
      wait_done(lat);
      chk_lat("hit_lat_r9", lat, 2);
      drop_req();

      // dirty 9, then reset during write-back word 40
      raise(1'b0, 1'b1, 10'd9);
      wait_done(lat);
      drop_req();
      rnd_en = 1'b0;
      push_wb(24'h080480);
      raise(1'b1, 1'b0, 10'd3);
      n = 0;
      while (!(mem_req && mem_we && mem_addr == 24'h0804A8) && n < 3000) begin
         @(negedge clk_50); n++;
      end
      checks++;
      if (!(mem_req && mem_we && mem_addr == 24'h0804A8)) begin
         errors++;
         $display("FAIL wb_word40 got addr=%h req=%b exp 0804a8 1", mem_addr, mem_req);
      end
      #3 reset = 1'b1;
      #1;
      checks++;
      if ({wb_ack, wb_done, bram_wren, mem_req, mem_we, busy} !== 6'b0 ||
          mem_addr !== 24'h0 || mem_wdata !== 32'h0 ||
          bram_addr !== 7'h0 || bram_data !== 32'h0) begin
         errors++;
         $display("FAIL async_reset got flags=%b addr=%h exp 0",
                  {wb_ack, wb_done, bram_wren, mem_req, mem_we, busy}, mem_addr);
      end
      mq.delete(); bq.delete();
      wb_read = 1'b0;
      repeat (3) @(negedge clk_50);
      reset = 1'b0;
      repeat (2) @(negedge clk_50);

      // read 9 after reset: no write-back
      push_fetch(24'h080480);
      raise(1'b1, 1'b0, 10'd9);
      wait_done(lat);
      drop_req();

      // read+write both high on block 2: treated as write
      push_fetch(24'h080100);
      raise(1'b1, 1'b1, 10'd2);
      wait_done(lat);
      @(negedge clk_50);
      wb_read = 1'b0;
      repeat (8) @(negedge clk_50);
      checks++;
      if ({wb_ack, wb_done} !== 2'b11) begin
         errors++;
         $display("FAIL hold_both got ack/done=%b%b exp 11", wb_ack, wb_done);
      end
      drop_req();

      // read 4 proves block 2 was dirty
      push_wb(24'h080100);
      push_fetch(24'h080200);
      raise(1'b1, 1'b0, 10'd4);
      wait_done(lat);
      drop_req();

      repeat (4) @(negedge clk_50);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
